// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: widths, FSM state encoding, bit-period helper.
package uart_pkg;

  localparam int CNT_W  = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int unsigned cycles_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter 0..CYCLES-1 with synchronous clear and terminal-count tick.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CYCLES = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == TERM);
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - streaming 8N1/8N2 UART transmitter with CTS flow control.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              cts_n,
  output logic              txd,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CPB = cycles_per_bit(CLK_FREQ, BAUD);

  uart_state_e       state_q, state_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_valid_q, hold_valid_d;
  logic              txd_q, txd_d;
  logic              cts_s1_q, cts_s2_q;
  logic              tick;
  logic              clear;
  logic              consume;
  logic              last_stop;

  // bit_idx doubles as the stop-bit counter while in STOP
  assign last_stop  = (STOP_BITS < 2) || bit_idx_q[0];
  assign s_ready    = !hold_valid_q;
  assign txd        = txd_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_STOP) && tick && last_stop;
  assign clear      = (state_q == ST_IDLE) || (state_d != state_q);

  uart_baud_gen #(
    .CYCLES(CPB)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    consume      = 1'b0;

    if (s_valid && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_data_d  = s_data;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (hold_valid_q && !cts_s2_q) begin
          consume = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d   = ST_STOP;
          bit_idx_d = 3'd0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          bit_idx_d = 3'd0;
          if (!last_stop) begin
            bit_idx_d = bit_idx_q + 3'd1;
          end else if (hold_valid_q && !cts_s2_q) begin
            consume = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (consume) begin
      shift_d      = hold_data_q;
      hold_valid_d = 1'b0;
    end

    // txd is registered from the next-state view so it lines up with state_q
    unique case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[bit_idx_d];
      ST_PARITY: txd_d = ^shift_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_idx_q    <= 3'd0;
      shift_q      <= '0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      txd_q        <= 1'b1;
      cts_s1_q     <= 1'b1;
      cts_s2_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      txd_q        <= txd_d;
      cts_s1_q     <= cts_n;
      cts_s2_q     <= cts_s1_q;
    end
  end

endmodule
